tlb_walk_arb: RTL and testbench
===============================

TLB_WALK_ARB -- requirements
Module: tlb_walk_arb

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration between ITLB and DTLB, 0 = fixed DTLB priority.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low; reset==0 forces the reset state immediately.
REQ-004 i_req  in  1  ITLB miss walk request, level, held until i_ack or dropped.
REQ-005 i_ea  in  32  ITLB miss EA, stable while i_req high.
REQ-006 i_ack  out  1  one-cycle walk-complete pulse to ITLB.
REQ-007 i_load  out  1  one-cycle ITLB insert strobe.
REQ-008 d_req, d_ea, d_ack, d_load  as REQ-004..007, for DTLB.
REQ-009 fault  out  3  MMU_FAULT_xxx code, valid while i_ack or d_ack.
REQ-010 new_ea  out  32; new_pa  out  32; new_pp  out  2; new_Kp, new_Ks, new_cacheable  out  1 each: shared TLB refill bus.
REQ-011 tlbi  in  1  any TLB invalidate (ALL or VA) issued this cycle.
REQ-012 ptw_req  out  1  walk request to page-table walker, level.
REQ-013 ptw_ea  out  32  registered EA of granted request.
REQ-014 ptw_done  in  1  one-cycle walk completion.
REQ-015 ptw_valid  in  1; ptw_fault  in  3; ptw_pa  in  32; ptw_pp  in  2; ptw_Kp, ptw_Ks, ptw_cacheable  in  1: walk result, sampled only with ptw_done.

Function
REQ-016 FSM states SHALL be IDLE, WALK, RESP; reset state IDLE.
REQ-017 IDLE: if any req high at posedge, register grant (I or D) and its EA into ptw_ea, clear kill flag, go WALK.
REQ-018 Arbitration when both requests are high: RR_EN=1 grants the requester not granted last (last_grant reset value = I, so first contention goes to D); RR_EN=0 always grants D.
REQ-019 WALK: ptw_req=1; ptw_ea held constant; on ptw_done register all ptw_* result fields, go RESP.
REQ-020 RESP (exactly one cycle): ptw_req=0, then go IDLE.
REQ-021 RESP, granted requester's req still high: its ack=1 and fault = ptw_fault if ptw_valid=0, else MMU_FAULT_NONE.
REQ-022 RESP, ptw_valid=1 and kill=0: granted requester's load=1; new_ea=ptw_ea; new_* = registered result.
REQ-023 Dropped request (granted req low at any point in WALK or RESP): the walk SHALL complete; load still per REQ-022; no ack.
REQ-024 tlbi high in WALK or in the cycle ptw_done arrives SHALL set kill; killed walk gives no load, ack with fault=MMU_FAULT_NONE (requester re-looks-up and misses again).
REQ-025 tlbi in IDLE or RESP has no effect on FSM; load in RESP is not suppressed by same-cycle tlbi (TLB applies invalidate and load in the same cycle).
REQ-026 ptw_done outside WALK SHALL be ignored.
REQ-027 Ungranted requester SHALL see no ack/load; its req remains pending and is arbitrated in the next IDLE.
REQ-028 A req high in the IDLE cycle following RESP is a new request; requesters drop req on the edge ending their ack cycle.
REQ-029 Latency: req sampled in IDLE at edge N -> ptw_req high cycle N+1; ptw_done at edge M -> ack/load in cycle M+1; minimum 3 cycles req-to-ack.
REQ-030 At most one of i_load/d_load and one of i_ack/d_ack high per cycle; new_* bus is 0 when no load.

Reset
REQ-031 reset==0 SHALL asynchronously force: state IDLE, last_grant=I, kill=0; ptw_req, ptw_ea, i_ack, d_ack, i_load, d_load, fault, all new_* = 0.
REQ-032 Reset mid-WALK abandons the walk with no ack/load; the walker is reset by the same signal.

Verification
REQ-033 i_req with i_ea=0x00401000; ptw_done after 4 cycles, valid, ptw_pa=0x00123000, pp=10 -> ptw_ea=0x00401000, single cycle of i_ack and i_load, new_pa=0x00123000, fault=NONE.
REQ-034 i_req and d_req raised same cycle, both held, after reset -> D walked first, then I; repeat with RR_EN=0 and d_req re-raised -> D granted twice.
REQ-035 d_req; walker returns ptw_valid=0, ptw_fault=MMU_FAULT_TF -> d_ack with fault=TF, d_load=0.
REQ-036 i_req granted, dropped 1 cycle later; valid result -> i_load=1 once, i_ack never.
REQ-037 d_req granted, tlbi pulsed during WALK; valid result -> d_ack=1, fault=NONE, d_load=0.
REQ-038 reset driven low mid-WALK between edges -> ptw_req and all outputs 0 immediately; after release with no req, state stays IDLE and a late ptw_done is ignored.

Source files
------------

// File: rtl/tlb_walk_arb.sv
// Arbitrates ITLB/DTLB miss walks onto a single page-table walker and returns
// the walk result on a shared refill bus. A walk is killed by a TLB invalidate while it is in flight.
module tlb_walk_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_ea,
  output logic        i_ack,
  output logic        i_load,
  input  logic        d_req,
  input  logic [31:0] d_ea,
  output logic        d_ack,
  output logic        d_load,
  output logic [2:0]  fault,
  output logic [31:0] new_ea,
  output logic [31:0] new_pa,
  output logic [1:0]  new_pp,
  output logic        new_Kp,
  output logic        new_Ks,
  output logic        new_cacheable,
  input  logic        tlbi,
  output logic        ptw_req,
  output logic [31:0] ptw_ea,
  input  logic        ptw_done,
  input  logic        ptw_valid,
  input  logic [2:0]  ptw_fault,
  input  logic [31:0] ptw_pa,
  input  logic [1:0]  ptw_pp,
  input  logic        ptw_Kp,
  input  logic        ptw_Ks,
  input  logic        ptw_cacheable
);
  localparam logic [2:0] MMU_FAULT_NONE = 3'd0;

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  fault;
    logic [31:0] pa;
    logic [1:0]  pp;
    logic        kp;
    logic        ks;
    logic        cacheable;
  } walk_res_t;

  state_t    state, nxt;
  walk_res_t res;
  logic      gnt_d, last_d, kill, drop;
  logic      gnt_req, pick_d, ack, load;

  // last_d resets to 0 (I granted last), so first contention goes to D
  assign pick_d  = d_req && (!i_req || !RR_EN || !last_d);
  assign gnt_req = gnt_d ? d_req : i_req;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) nxt = WALK;
      WALK:    if (ptw_done) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      gnt_d  <= 1'b0;
      last_d <= 1'b0;
      kill   <= 1'b0;
      drop   <= 1'b0;
      ptw_ea <= '0;
      res    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (i_req || d_req) begin
          gnt_d  <= pick_d;
          last_d <= pick_d;
          ptw_ea <= pick_d ? d_ea : i_ea;
          kill   <= 1'b0;
          drop   <= 1'b0;
        end
        WALK: begin
          if (tlbi) kill <= 1'b1;
          if (!gnt_req) drop <= 1'b1;
          if (ptw_done)
            res <= '{valid: ptw_valid, fault: ptw_fault, pa: ptw_pa, pp: ptw_pp,
                     kp: ptw_Kp, ks: ptw_Ks, cacheable: ptw_cacheable};
        end
        default: ;
      endcase
    end
  end

  // A requester that let go at any point during the walk gets no ack, but
  // the refill still happens so the TLB benefits from the work.
  assign ptw_req = (state == WALK);
  assign ack     = (state == RESP) && gnt_req && !drop;
  assign load    = (state == RESP) && res.valid && !kill;

  assign i_ack  = ack && !gnt_d;
  assign d_ack  = ack && gnt_d;
  assign i_load = load && !gnt_d;
  assign d_load = load && gnt_d;
  assign fault  = (ack && !kill && !res.valid) ? res.fault : MMU_FAULT_NONE;

  assign new_ea        = load ? ptw_ea : '0;
  assign new_pa        = load ? res.pa : '0;
  assign new_pp        = load ? res.pp : '0;
  assign new_Kp        = load && res.kp;
  assign new_Ks        = load && res.ks;
  assign new_cacheable = load && res.cacheable;
endmodule

// File: tb/tb_tlb_walk_arb.sv
// Directed bench for tlb_walk_arb: two instances (round-robin and fixed-D)
// share stimulus; the fixed-priority one is only checked during contention.
module tb_tlb_walk_arb;
  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_TF   = 3'd1;

  logic        clk = 1'b0, reset = 1'b0;
  logic        i_req = 0, d_req = 0, tlbi = 0, ptw_done = 0, ptw_valid = 0;
  logic [31:0] i_ea = 0, d_ea = 0, ptw_pa = 0;
  logic [2:0]  ptw_fault = 0;
  logic [1:0]  ptw_pp = 0;
  logic        ptw_Kp = 0, ptw_Ks = 0, ptw_cacheable = 0;

  logic        i_ack, i_load, d_ack, d_load, new_Kp, new_Ks, new_cacheable, ptw_req;
  logic [2:0]  fault;
  logic [31:0] new_ea, new_pa, ptw_ea;
  logic [1:0]  new_pp;

  logic        i_ack0, i_load0, d_ack0, d_load0, new_Kp0, new_Ks0, new_cacheable0, ptw_req0;
  logic [2:0]  fault0;
  logic [31:0] new_ea0, new_pa0, ptw_ea0;
  logic [1:0]  new_pp0;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  tlb_walk_arb #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_ea(i_ea), .i_ack(i_ack), .i_load(i_load),
    .d_req(d_req), .d_ea(d_ea), .d_ack(d_ack), .d_load(d_load),
    .fault(fault), .new_ea(new_ea), .new_pa(new_pa), .new_pp(new_pp),
    .new_Kp(new_Kp), .new_Ks(new_Ks), .new_cacheable(new_cacheable),
    .tlbi(tlbi), .ptw_req(ptw_req), .ptw_ea(ptw_ea), .ptw_done(ptw_done),
    .ptw_valid(ptw_valid), .ptw_fault(ptw_fault), .ptw_pa(ptw_pa), .ptw_pp(ptw_pp),
    .ptw_Kp(ptw_Kp), .ptw_Ks(ptw_Ks), .ptw_cacheable(ptw_cacheable));

  tlb_walk_arb #(.RR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_ea(i_ea), .i_ack(i_ack0), .i_load(i_load0),
    .d_req(d_req), .d_ea(d_ea), .d_ack(d_ack0), .d_load(d_load0),
    .fault(fault0), .new_ea(new_ea0), .new_pa(new_pa0), .new_pp(new_pp0),
    .new_Kp(new_Kp0), .new_Ks(new_Ks0), .new_cacheable(new_cacheable0),
    .tlbi(tlbi), .ptw_req(ptw_req0), .ptw_ea(ptw_ea0), .ptw_done(ptw_done),
    .ptw_valid(ptw_valid), .ptw_fault(ptw_fault), .ptw_pa(ptw_pa), .ptw_pp(ptw_pp),
    .ptw_Kp(ptw_Kp), .ptw_Ks(ptw_Ks), .ptw_cacheable(ptw_cacheable));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // packed handshake view: {ptw_req, i_ack, i_load, d_ack, d_load}
  function automatic logic [31:0] hs();
    return {27'd0, ptw_req, i_ack, i_load, d_ack, d_load};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse(input logic v, input logic [2:0] f, input logic [31:0] pa,
                            input logic [1:0] pp);
    ptw_done = 1; ptw_valid = v; ptw_fault = f; ptw_pa = pa; ptw_pp = pp;
    ptw_Kp = 1; ptw_Ks = 0; ptw_cacheable = 1;
  endtask

  task automatic done_clear();
    ptw_done = 0; ptw_valid = 0; ptw_fault = 0; ptw_pa = 0; ptw_pp = 0;
    ptw_Kp = 0; ptw_Ks = 0; ptw_cacheable = 0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_hs", hs(), 32'h0);
    chk("rst_ptw_ea", ptw_ea, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    reset = 1;

    // single ITLB walk, done after 4 WALK cycles
    cyc(); i_req = 1; i_ea = 32'h0040_1000; #1;
    chk("t1_idle_hs", hs(), 32'h0);
    cyc(); #1;
    chk("t1_walk_hs", hs(), 32'h10);
    chk("t1_ptw_ea", ptw_ea, 32'h0040_1000);
    cyc(); cyc();
    cyc(); done_pulse(1, F_NONE, 32'h0012_3000, 2'b10); #1;
    chk("t1_w4_ea_held", ptw_ea, 32'h0040_1000);
    cyc(); done_clear(); #1;
    chk("t1_resp_hs", hs(), 32'h0C);
    chk("t1_new_pa", new_pa, 32'h0012_3000);
    chk("t1_new_ea", new_ea, 32'h0040_1000);
    chk("t1_new_pp", 32'(new_pp), 32'h2);
    chk("t1_new_bits", {29'd0, new_Kp, new_Ks, new_cacheable}, 32'h5);
    chk("t1_fault", 32'(fault), 32'(F_NONE));
    cyc(); i_req = 0; #1;
    chk("t1_after_hs", hs(), 32'h0);
    chk("t1_bus_zero", new_pa, 32'h0);

    // contention: both raised together -> D first on both instances
    cyc(); i_req = 1; d_req = 1; i_ea = 32'h1000_0000; d_ea = 32'h2000_0000; #1;
    cyc(); #1;
    chk("t2_rr_first", ptw_ea, 32'h2000_0000);
    chk("t2_fx_first", ptw_ea0, 32'h2000_0000);
    cyc(); done_pulse(1, F_NONE, 32'h0AAA_A000, 2'b01); #1;
    cyc(); done_clear(); #1;
    chk("t2_resp_hs", hs(), 32'h03);
    chk("t2_new_ea", new_ea, 32'h2000_0000);
    // D drops then re-raises as a new request in the following IDLE
    cyc(); #1;
    chk("t2_idle_hs", hs(), 32'h0);
    cyc(); #1;
    chk("t2_rr_second", ptw_ea, 32'h1000_0000);
    chk("t2_fx_second", ptw_ea0, 32'h2000_0000);
    i_req = 0; d_req = 0;
    reset = 0; #2; reset = 1;

    // DTLB walk returns a translation fault
    cyc(); d_req = 1; d_ea = 32'h3000_4000; #1;
    cyc(); #1;
    chk("t3_ptw_ea", ptw_ea, 32'h3000_4000);
    cyc(); done_pulse(0, F_TF, 32'hDEAD_0000, 2'b11); #1;
    cyc(); done_clear(); #1;
    chk("t3_resp_hs", hs(), 32'h02);
    chk("t3_fault", 32'(fault), 32'(F_TF));
    chk("t3_bus_zero", new_pa, 32'h0);
    cyc(); d_req = 0; #1;
    chk("t3_fault_clr", 32'(fault), 32'h0);

    // ITLB drops during WALK: load only; tlbi in RESP does not block load
    cyc(); i_req = 1; i_ea = 32'h0050_0000; #1;
    cyc(); i_req = 0; #1;
    chk("t4_walk_hs", hs(), 32'h10);
    cyc(); done_pulse(1, F_NONE, 32'h0077_7000, 2'b00); #1;
    cyc(); done_clear(); tlbi = 1; #1;
    chk("t4_resp_hs", hs(), 32'h04);
    chk("t4_new_ea", new_ea, 32'h0050_0000);
    cyc(); tlbi = 0; #1;
    chk("t4_after_hs", hs(), 32'h0);

    // tlbi during WALK kills the refill but still acks
    cyc(); d_req = 1; d_ea = 32'h0060_0000; #1;
    cyc(); tlbi = 1; #1;
    cyc(); tlbi = 0; done_pulse(1, F_NONE, 32'h0088_8000, 2'b10); #1;
    cyc(); done_clear(); #1;
    chk("t5_resp_hs", hs(), 32'h02);
    chk("t5_fault", 32'(fault), 32'(F_NONE));
    chk("t5_bus_zero", new_pa, 32'h0);
    cyc(); d_req = 0; #1;

    // tlbi in the same cycle as ptw_done also kills
    cyc(); i_req = 1; i_ea = 32'h0070_0000; #1;
    cyc(); tlbi = 1; done_pulse(1, F_NONE, 32'h0099_9000, 2'b10); #1;
    cyc(); tlbi = 0; done_clear(); #1;
    chk("t6_resp_hs", hs(), 32'h08);
    cyc(); i_req = 0; #1;

    // async reset mid-WALK, then a late ptw_done is ignored
    cyc(); i_req = 1; i_ea = 32'h0080_0000; #1;
    cyc(); #1;
    chk("t7_walk_hs", hs(), 32'h10);
    #2; reset = 0; #1;
    chk("t7_rst_hs", hs(), 32'h0);
    chk("t7_rst_ea", ptw_ea, 32'h0);
    i_req = 0; #1; reset = 1;
    cyc(); done_pulse(1, F_NONE, 32'h00AA_A000, 2'b10); #1;
    chk("t7_late_done", hs(), 32'h0);
    cyc(); done_clear(); #1;
    chk("t7_idle1", hs(), 32'h0);
    chk("t7_idle1_bus", new_pa, 32'h0);
    cyc(); #1;
    chk("t7_idle2", hs(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
